// File: rtl/crossing_gate_ctrl.sv
// ---------------------------------------------------------------------------
// crossing_gate_ctrl
//
// Level-crossing gate controller. Train detections from the east and west
// track sequence detectors drive a warning / lower / hold / clear / raise
// cycle. A train-in-zone count decides when the crossing is free again. All
// outputs are registered and change on the same edge as the state register.
//
// Parameters
//   WARN_CYC   cycles of lamp/buzzer warning before the gate lowers (>= 1)
//   MOVE_TMO   cycles allowed for gate travel before a fault (>= 1)
//   CLEAR_CYC  hold cycles after the last train exits before raising (>= 1)
//   BLINK_HALF lamp blink half-period in cycles (>= 1)
//
// Ports
//   clk          single clock, rising edge
//   rst_n        asynchronous active-low reset
//   det_e/det_w  one-cycle detection pulses, east / west track
//   gate_dn_sw   gate-fully-down limit switch
//   gate_up_sw   gate-fully-up limit switch
//   lamp         warning lamp
//   buzzer       audible warning
//   gate_dn_cmd  motor lower command
//   gate_up_cmd  motor raise command
//   fault        latched fault, cleared only by reset
//   occ[2:0]     trains currently inside the crossing zone
//
// Build option
//   CROSSING_LAMP_BLINK_EN  when defined, the lamp blinks with half-period
//                           BLINK_HALF instead of burning steadily.
// ---------------------------------------------------------------------------
module crossing_gate_ctrl #(
  parameter logic [15:0] WARN_CYC   = 16'd50,
  parameter logic [15:0] MOVE_TMO   = 16'd200,
  parameter logic [15:0] CLEAR_CYC  = 16'd30,
  parameter logic [7:0]  BLINK_HALF = 8'd10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       det_e,
  input  logic       det_w,
  input  logic       gate_dn_sw,
  input  logic       gate_up_sw,
  output logic       lamp,
  output logic       buzzer,
  output logic       gate_dn_cmd,
  output logic       gate_up_cmd,
  output logic       fault,
  output logic [2:0] occ
);

  if (WARN_CYC == 16'd0 || MOVE_TMO == 16'd0 || CLEAR_CYC == 16'd0 ||
      BLINK_HALF == 8'd0) begin : g_param_check
    $error("crossing_gate_ctrl: all timing parameters must be at least 1");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WARN,
    ST_LOWER,
    ST_CLOSED,
    ST_CLEAR,
    ST_RAISE,
    ST_FAULT
  } state_e;

  // Direction of entry: the side whose pulses count trains in.
  localparam logic DIR_E = 1'b0;
  localparam logic DIR_W = 1'b1;

  state_e      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [2:0]  occ_q, occ_d;
  logic        dir_q, dir_d;
  logic        lamp_q, lamp_d;
  logic        buzzer_q, buzzer_d;
  logic        dn_cmd_q, dn_cmd_d;
  logic        up_cmd_q, up_cmd_d;
  logic        fault_q, fault_d;
  logic        lamp_tbl;

  logic        any_det;
  logic        det_dir;
  logic        entry_p;
  logic        exit_p;
  logic        sw_conflict;
  logic        timer_done;
  logic [2:0]  occ_trk;

  assign any_det     = det_e | det_w;
  assign det_dir     = det_e ? DIR_E : DIR_W;   // east wins a tie
  assign entry_p     = (dir_q == DIR_E) ? det_e : det_w;
  assign exit_p      = (dir_q == DIR_E) ? det_w : det_e;
  assign sw_conflict = gate_dn_sw & gate_up_sw;
  assign timer_done  = (timer_q == 16'd0);

  // Saturating train count; simultaneous entry and exit cancel out.
  always_comb begin
    occ_trk = occ_q;
    if (entry_p && !exit_p && occ_q != 3'd7) begin
      occ_trk = occ_q + 3'd1;
    end else if (exit_p && !entry_p && occ_q != 3'd0) begin
      occ_trk = occ_q - 3'd1;
    end
  end

  // Next-state, occupancy and direction.
  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    occ_d   = occ_q;
    dir_d   = dir_q;
    unique case (state_q)
      ST_IDLE: begin
        if (any_det) begin
          dir_d   = det_dir;
          occ_d   = 3'd1;
          state_d = ST_WARN;
        end
      end
      ST_WARN: begin
        occ_d = occ_trk;
        if (timer_done) state_d = ST_LOWER;
      end
      ST_LOWER: begin
        // The gate always finishes lowering, even if the zone empties.
        occ_d = occ_trk;
        if (gate_dn_sw)      state_d = ST_CLOSED;
        else if (timer_done) state_d = ST_FAULT;
      end
      ST_CLOSED: begin
        occ_d = occ_trk;
        if (occ_trk == 3'd0) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        if (any_det) begin
          dir_d   = det_dir;
          occ_d   = 3'd1;
          state_d = ST_CLOSED;
        end else if (timer_done) begin
          state_d = ST_RAISE;
        end
      end
      ST_RAISE: begin
        // A new train outranks a completed raise or a travel timeout.
        if (any_det) begin
          dir_d   = det_dir;
          occ_d   = 3'd1;
          state_d = ST_LOWER;
        end else if (gate_up_sw) begin
          state_d = ST_IDLE;
        end else if (timer_done) begin
          state_d = ST_FAULT;
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_FAULT;
      end
    endcase
    // Both limit switches closed means the sensors cannot be trusted.
    if (sw_conflict) state_d = ST_FAULT;
  end

  // One shared down-counter, reloaded whenever a new state is entered.
  always_comb begin
    timer_d = 16'd0;
    if (state_d != state_q) begin
      unique case (state_d)
        ST_WARN:  timer_d = WARN_CYC - 16'd1;
        ST_LOWER: timer_d = MOVE_TMO - 16'd1;
        ST_CLEAR: timer_d = CLEAR_CYC - 16'd1;
        ST_RAISE: timer_d = MOVE_TMO - 16'd1;
        default:  timer_d = 16'd0;
      endcase
    end else if (!timer_done) begin
      timer_d = timer_q - 16'd1;
    end
  end

  // Output table, evaluated on the next state so outputs and state
  // register together.
  always_comb begin
    lamp_tbl = 1'b0;
    buzzer_d = 1'b0;
    dn_cmd_d = 1'b0;
    up_cmd_d = 1'b0;
    fault_d  = 1'b0;
    unique case (state_d)
      ST_WARN:   begin lamp_tbl = 1'b1; buzzer_d = 1'b1; end
      ST_LOWER:  begin lamp_tbl = 1'b1; buzzer_d = 1'b1; dn_cmd_d = 1'b1; end
      ST_CLOSED: begin lamp_tbl = 1'b1; end
      ST_CLEAR:  begin lamp_tbl = 1'b1; end
      ST_RAISE:  begin lamp_tbl = 1'b1; up_cmd_d = 1'b1; end
      ST_FAULT:  begin lamp_tbl = 1'b1; buzzer_d = 1'b1; fault_d = 1'b1; end
      default:   begin lamp_tbl = 1'b0; end
    endcase
  end

`ifdef CROSSING_LAMP_BLINK_EN
  logic [7:0] blink_cnt_q, blink_cnt_d;

  // Lamp starts lit when leaving IDLE, then toggles every BLINK_HALF cycles.
  always_comb begin
    blink_cnt_d = 8'd0;
    lamp_d      = 1'b0;
    if (lamp_tbl) begin
      if (state_q == ST_IDLE) begin
        lamp_d      = 1'b1;
        blink_cnt_d = BLINK_HALF - 8'd1;
      end else if (blink_cnt_q == 8'd0) begin
        lamp_d      = ~lamp_q;
        blink_cnt_d = BLINK_HALF - 8'd1;
      end else begin
        lamp_d      = lamp_q;
        blink_cnt_d = blink_cnt_q - 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) blink_cnt_q <= 8'd0;
    else        blink_cnt_q <= blink_cnt_d;
  end
`else
  assign lamp_d = lamp_tbl;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  // NOTE: every flop here is control state, so all of it is reset; the
  // reset is asynchronous so the motor commands drop without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      timer_q  <= 16'd0;
      occ_q    <= 3'd0;
      dir_q    <= DIR_E;
      lamp_q   <= 1'b0;
      buzzer_q <= 1'b0;
      dn_cmd_q <= 1'b0;
      up_cmd_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      occ_q    <= occ_d;
      dir_q    <= dir_d;
      lamp_q   <= lamp_d;
      buzzer_q <= buzzer_d;
      dn_cmd_q <= dn_cmd_d;
      up_cmd_q <= up_cmd_d;
      fault_q  <= fault_d;
    end
  end

  assign lamp        = lamp_q;
  assign buzzer      = buzzer_q;
  assign gate_dn_cmd = dn_cmd_q;
  assign gate_up_cmd = up_cmd_q;
  assign fault       = fault_q;
  assign occ         = occ_q;

endmodule

// File: tb/tb_crossing_gate_ctrl.sv
// ---------------------------------------------------------------------------
// tb_crossing_gate_ctrl
//
// Directed scenarios followed by randomized traffic against a behavioural
// model of the crossing. The model counts elapsed cycles per phase and keeps
// the train count with plain clamped arithmetic. A small gate plant drives
// the limit switches from the model phase with randomized travel delays.
// ---------------------------------------------------------------------------
module tb_crossing_gate_ctrl;

  localparam int WARN_CYC  = 50;
  localparam int MOVE_TMO  = 200;
  localparam int CLEAR_CYC = 30;

  // Output patterns {lamp, buzzer, gate_dn_cmd, gate_up_cmd, fault}.
  localparam logic [4:0] P_IDLE   = 5'b00000;
  localparam logic [4:0] P_WARN   = 5'b11000;
  localparam logic [4:0] P_LOWER  = 5'b11100;
  localparam logic [4:0] P_CLOSED = 5'b10000;
  localparam logic [4:0] P_RAISE  = 5'b10010;
  localparam logic [4:0] P_FAULT  = 5'b11001;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       det_e = 1'b0;
  logic       det_w = 1'b0;
  logic       gate_dn_sw = 1'b0;
  logic       gate_up_sw = 1'b0;
  logic       lamp, buzzer, gate_dn_cmd, gate_up_cmd, fault;
  logic [2:0] occ;

  crossing_gate_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .det_e      (det_e),
    .det_w      (det_w),
    .gate_dn_sw (gate_dn_sw),
    .gate_up_sw (gate_up_sw),
    .lamp       (lamp),
    .buzzer     (buzzer),
    .gate_dn_cmd(gate_dn_cmd),
    .gate_up_cmd(gate_up_cmd),
    .fault      (fault),
    .occ        (occ)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_WARN, M_LOWER, M_CLOSED, M_CLEAR, M_RAISE, M_FAULT} mphase_t;

  mphase_t m_ph  = M_IDLE;
  int      m_cnt = 0;     // cycles already spent in the current phase
  int      m_occ = 0;
  logic    m_dir = 1'b0;  // 0 = east entry, 1 = west entry

  function automatic logic [4:0] exp_outs(input mphase_t p);
    case (p)
      M_WARN:   return P_WARN;
      M_LOWER:  return P_LOWER;
      M_CLOSED: return P_CLOSED;
      M_CLEAR:  return P_CLOSED;
      M_RAISE:  return P_RAISE;
      M_FAULT:  return P_FAULT;
      default:  return P_IDLE;
    endcase
  endfunction

  task automatic model_step(input logic e, input logic w,
                            input logic dn, input logic up);
    mphase_t nx = m_ph;
    int      occ_n = m_occ;
    logic    dir_n = m_dir;
    int      ent = (m_dir ? w : e) ? 1 : 0;
    int      ext = (m_dir ? e : w) ? 1 : 0;
    int      tracked = m_occ + ent - ext;
    if (tracked > 7) tracked = 7;
    if (tracked < 0) tracked = 0;
    case (m_ph)
      M_IDLE: if (e || w) begin dir_n = !e; occ_n = 1; nx = M_WARN; end
      M_WARN: begin
        occ_n = tracked;
        if (m_cnt == WARN_CYC - 1) nx = M_LOWER;
      end
      M_LOWER: begin
        occ_n = tracked;
        if (dn) nx = M_CLOSED;
        else if (m_cnt == MOVE_TMO - 1) nx = M_FAULT;
      end
      M_CLOSED: begin
        occ_n = tracked;
        if (tracked == 0) nx = M_CLEAR;
      end
      M_CLEAR: begin
        if (e || w) begin dir_n = !e; occ_n = 1; nx = M_CLOSED; end
        else if (m_cnt == CLEAR_CYC - 1) nx = M_RAISE;
      end
      M_RAISE: begin
        if (e || w) begin dir_n = !e; occ_n = 1; nx = M_LOWER; end
        else if (up) nx = M_IDLE;
        else if (m_cnt == MOVE_TMO - 1) nx = M_FAULT;
      end
      default: nx = M_FAULT;
    endcase
    if (dn && up) nx = M_FAULT;
    m_cnt = (nx != m_ph) ? 0 : m_cnt + 1;
    m_ph  = nx;
    m_occ = occ_n;
    m_dir = dir_n;
  endtask

  // ---------------- gate plant ----------------
  bit   rand_mode = 1'b0;
  int   dn_delay = 20;
  int   up_delay = 10;
  bit   sw_ovr = 1'b0;
  logic ovr_dn = 1'b0;
  logic ovr_up = 1'b0;

  function automatic int pick_delay();
    if ($urandom_range(0, 7) == 0) return int'($urandom_range(150, 260));
    return int'($urandom_range(0, 40));
  endfunction

  task automatic compare_all();
    check("outs", {lamp, buzzer, gate_dn_cmd, gate_up_cmd, fault}, exp_outs(m_ph));
    check("occ", occ, m_occ);
    check("dir", dut.dir_q, m_dir);
  endtask

  // One clock: drive on the falling edge, step the model, sample after
  // the rising edge.
  task automatic cycle(input logic e, input logic w);
    logic dn, up;
    @(negedge clk);
    if (rand_mode && m_cnt == 0 && m_ph == M_LOWER) dn_delay = pick_delay();
    if (rand_mode && m_cnt == 0 && m_ph == M_RAISE) up_delay = pick_delay();
    if (sw_ovr) begin
      dn = ovr_dn;
      up = ovr_up;
    end else begin
      dn = (m_ph == M_LOWER && m_cnt >= dn_delay) || m_ph == M_CLOSED || m_ph == M_CLEAR;
      up = m_ph == M_IDLE || m_ph == M_WARN || (m_ph == M_RAISE && m_cnt >= up_delay);
    end
    det_e = e;
    det_w = w;
    gate_dn_sw = dn;
    gate_up_sw = up;
    model_step(e, w, dn, up);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  // Idle cycles until the DUT shows a pattern; n is the cycles taken.
  task automatic wait_outs(input string tag, input logic [4:0] pat,
                           input int budget, output int n);
    n = 0;
    while ({lamp, buzzer, gate_dn_cmd, gate_up_cmd, fault} !== pat && n < budget) begin
      cycle(1'b0, 1'b0);
      n++;
    end
    check(tag, {lamp, buzzer, gate_dn_cmd, gate_up_cmd, fault}, pat);
  endtask

  // Asynchronous reset asserted mid-cycle, away from any rising edge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    det_e = 1'b0;
    det_w = 1'b0;
    gate_dn_sw = 1'b0;
    gate_up_sw = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_outs", {lamp, buzzer, gate_dn_cmd, gate_up_cmd, fault}, P_IDLE);
    check("rst_occ", occ, 3'd0);
    check("rst_dir", dut.dir_q, 1'b0);
    m_ph = M_IDLE;
    m_cnt = 0;
    m_occ = 0;
    m_dir = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    do_reset();
    check("idle_after_reset", {lamp, buzzer, gate_dn_cmd, gate_up_cmd, fault}, P_IDLE);

    // Normal pass.
    dn_delay = 20;
    up_delay = 10;
    cycle(1'b1, 1'b0);
    check("np_occ1", occ, 3'd1);
    wait_outs("np_to_lower", P_LOWER, 80, n);
    check("np_warn_len", n, WARN_CYC);
    wait_outs("np_to_closed", P_CLOSED, 40, n);
    check("np_lower_len", n, 21);
    cycle(1'b0, 1'b1);
    check("np_occ0", occ, 3'd0);
    wait_outs("np_to_raise", P_RAISE, 60, n);
    check("np_clear_len", n, CLEAR_CYC);
    wait_outs("np_to_idle", P_IDLE, 30, n);

    // Two trains, then re-entry during RAISE.
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    check("tt_occ2", occ, 3'd2);
    wait_outs("tt_to_lower", P_LOWER, 80, n);
    wait_outs("tt_to_closed", P_CLOSED, 40, n);
    cycle(1'b0, 1'b1);
    check("tt_occ1", occ, 3'd1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0);
    check("tt_still_closed", {lamp, buzzer, gate_dn_cmd, gate_up_cmd, fault}, P_CLOSED);
    cycle(1'b0, 1'b1);
    check("tt_occ0", occ, 3'd0);
    up_delay = 100;
    wait_outs("re_to_raise", P_RAISE, 60, n);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    check("re_lower", {lamp, buzzer, gate_dn_cmd, gate_up_cmd, fault}, P_LOWER);
    check("re_occ1", occ, 3'd1);
    check("re_dir_w", dut.dir_q, 1'b1);
    wait_outs("re_to_closed", P_CLOSED, 40, n);
    cycle(1'b1, 1'b0);            // east is now the exit side
    check("re_occ0", occ, 3'd0);
    up_delay = 10;
    wait_outs("re_to_raise2", P_RAISE, 60, n);
    wait_outs("re_to_idle", P_IDLE, 30, n);

    // Timeout while lowering.
    dn_delay = 1000;
    cycle(1'b1, 1'b0);
    wait_outs("to_lower", P_LOWER, 80, n);
    wait_outs("to_fault", P_FAULT, 400, n);
    check("to_tmo_len", n, MOVE_TMO);
    for (int i = 0; i < 20; i++) cycle(i[0], !i[0]);
    check("to_fault_held", fault, 1'b1);
    do_reset();

    // Tie in IDLE, then limit-switch conflict while closed.
    dn_delay = 20;
    cycle(1'b1, 1'b1);
    check("tie_dir_e", dut.dir_q, 1'b0);
    check("tie_occ1", occ, 3'd1);
    wait_outs("tie_to_lower", P_LOWER, 80, n);
    wait_outs("tie_to_closed", P_CLOSED, 40, n);
    sw_ovr = 1'b1;
    ovr_dn = 1'b1;
    ovr_up = 1'b1;
    cycle(1'b0, 1'b0);
    check("cf_fault", {lamp, buzzer, gate_dn_cmd, gate_up_cmd, fault}, P_FAULT);
    sw_ovr = 1'b0;
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0);
    do_reset();

    // Reset in the middle of LOWER.
    dn_delay = 1000;
    cycle(1'b0, 1'b1);
    wait_outs("rl_to_lower", P_LOWER, 80, n);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0);
    do_reset();
    cycle(1'b0, 1'b0);
    check("rl_idle", {lamp, buzzer, gate_dn_cmd, gate_up_cmd, fault}, P_IDLE);

    // Randomized traffic.
    rand_mode = 1'b1;
    for (int ep = 0; ep < 25; ep++) begin
      do_reset();
      for (int c = 0; c < 600; c++) begin
        logic e, w;
        e = ($urandom_range(0, 29) == 0);
        w = ($urandom_range(0, 29) == 0);
        sw_ovr = ($urandom_range(0, 1999) == 0);
        ovr_dn = 1'b1;
        ovr_up = 1'b1;
        cycle(e, w);
        sw_ovr = 1'b0;
        if ($urandom_range(0, 1499) == 0) do_reset();
        if (m_ph == M_FAULT && m_cnt > 30) break;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
